// File: rtl/audio_io_port_if.sv
// audio_io_port_if: cpu data-bus port of the audio I/O unit
//   ram_r  : read strobe, pops RX FIFO when addressed
//   ram_w  : write strobe
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data, valid the cycle after ram_r
interface audio_io_port_if #(
   parameter int DWIDTH = 32
);
   logic              ram_r;
   logic              ram_w;
   logic [7:0]        addr;
   logic [DWIDTH-1:0] wdata;
   logic [DWIDTH-1:0] rdata;
   modport master (output ram_r, ram_w, addr, wdata, input rdata);
   modport slave  (input ram_r, ram_w, addr, wdata, output rdata);
endinterface

// File: rtl/audio_io_port.sv
// audio_io_port: memory-mapped multi-channel audio I/O with RX/TX FIFOs, DAC pacing and sticky error flags
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   bus             : cpu bus slave (ram_r, ram_w, addr, wdata -> rdata)
//   i_adc_valid/ch/data : ADC sample strobe, channel, two's complement sample
//   i_dac_tick      : sample-rate strobe, pops every TX FIFO into o_dac_out
//   o_dac_out       : channel c at [c*SWIDTH +: SWIDTH]
//   o_dac_valid     : pulses one cycle after o_dac_out updates
//   o_irq           : level interrupt, only when AUDIO_IO_IRQ_EN is defined
// Map: 0x00+c RX_DATA, 0x10+c TX_DATA, 0x20 STATUS, 0x21 CLEAR, 0x22 IRQ_MASK (AUDIO_IO_IRQ_EN)
module audio_io_port #(
   parameter int DWIDTH = 32,
   parameter int SWIDTH = 20,
   parameter int NCH    = 2,
   parameter int DEPTH  = 8,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   audio_io_port_if.slave          bus,
   input  logic                    i_adc_valid,
   input  logic [CW-1:0]           i_adc_ch,
   input  logic [SWIDTH-1:0]       i_adc_data,
   input  logic                    i_dac_tick,
   output logic [NCH*SWIDTH-1:0]   o_dac_out,
   output logic                    o_dac_valid,
   output logic                    o_irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   logic [NCH-1:0]    w_rx_ne, w_tx_full, w_rx_ovf, w_und;
   logic [SWIDTH-1:0] w_rx_head [NCH];
   logic [31:0]       w_status, w_clr;
   logic [DWIDTH-1:0] w_rdata, r_rdata;
   logic              r_tick_q, r_dac_valid;
   assign w_clr    = (bus.ram_w && bus.addr == 8'h21) ? 32'(bus.wdata) : '0;
   assign w_status = {8'(w_und), 8'(w_rx_ovf), 8'(w_tx_full), 8'(w_rx_ne)};
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [SWIDTH-1:0] r_rx_mem [DEPTH];
      logic [SWIDTH-1:0] r_tx_mem [DEPTH];
      logic [AW-1:0]     r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
      logic [NW-1:0]     r_rx_cnt, r_tx_cnt;
      logic [SWIDTH-1:0] r_dac;
      logic              r_rx_ovf, r_und;
      logic              w_rx_pop_req, w_rx_push_req, w_tx_push_req;
      logic              w_rx_pop, w_rx_push, w_tx_pop, w_tx_push;
      assign w_rx_pop_req  = bus.ram_r && bus.addr == 8'(c);
      assign w_rx_push_req = i_adc_valid && i_adc_ch == CW'(c);
      assign w_tx_push_req = bus.ram_w && bus.addr == 8'(16 + c);
      // pops never bypass: an empty FIFO underruns even if a push lands this cycle
      assign w_rx_pop  = w_rx_pop_req && r_rx_cnt != '0;
      assign w_tx_pop  = i_dac_tick && r_tx_cnt != '0;
      // a same-cycle pop frees a slot, so a full FIFO still accepts the push
      assign w_rx_push = w_rx_push_req && (r_rx_cnt != NW'(DEPTH) || w_rx_pop);
      assign w_tx_push = w_tx_push_req && (r_tx_cnt != NW'(DEPTH) || w_tx_pop);
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
            r_dac    <= '0;
            r_rx_ovf <= 1'b0;
            r_und    <= 1'b0;
         end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_tx_pop)  r_dac   <= r_tx_mem[r_tx_rp];
            r_rx_cnt <= r_rx_cnt + NW'(w_rx_push) - NW'(w_rx_pop);
            r_tx_cnt <= r_tx_cnt + NW'(w_tx_push) - NW'(w_tx_pop);
            // set terms are OR-ed after the clear mask so a same-cycle set wins
            r_rx_ovf <= (w_rx_push_req && !w_rx_push) | (r_rx_ovf & ~w_clr[16+c]);
            r_und    <= (w_rx_pop_req && !w_rx_pop) | (i_dac_tick && !w_tx_pop) | (r_und & ~w_clr[24+c]);
         end
      end
      always_ff @(posedge i_clk) begin
         if (w_rx_push) r_rx_mem[r_rx_wp] <= i_adc_data;
         if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.wdata[SWIDTH-1:0];
      end
      assign w_rx_ne[c]                   = r_rx_cnt != '0;
      assign w_tx_full[c]                 = r_tx_cnt == NW'(DEPTH);
      assign w_rx_ovf[c]                  = r_rx_ovf;
      assign w_und[c]                     = r_und;
      assign w_rx_head[c]                 = r_rx_mem[r_rx_rp];
      assign o_dac_out[c*SWIDTH +: SWIDTH] = r_dac;
   end
`ifdef AUDIO_IO_IRQ_EN
   logic [31:0] r_irq_mask;
   logic        r_irq;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_irq_mask <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (bus.ram_w && bus.addr == 8'h22) r_irq_mask <= 32'(bus.wdata);
         r_irq <= |(w_status & r_irq_mask);
      end
   end
   assign o_irq = r_irq;
`else
   assign o_irq = 1'b0;
`endif
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < NCH; i++)
         if (bus.addr == 8'(i) && w_rx_ne[i]) w_rdata = DWIDTH'($signed(w_rx_head[i]));
      if (bus.addr == 8'h20) w_rdata = DWIDTH'(w_status);
`ifdef AUDIO_IO_IRQ_EN
      if (bus.addr == 8'h22) w_rdata = DWIDTH'(r_irq_mask);
`endif
   end
   // dac_out updates on the edge after the tick; dac_valid follows one cycle later
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata     <= '0;
         r_tick_q    <= 1'b0;
         r_dac_valid <= 1'b0;
      end else begin
         if (bus.ram_r) r_rdata <= w_rdata;
         r_tick_q    <= i_dac_tick;
         r_dac_valid <= r_tick_q;
      end
   end
   assign bus.rdata   = r_rdata;
   assign o_dac_valid = r_dac_valid;
endmodule

// File: tb/tb_audio_io_port.sv
// tb_audio_io_port: directed and randomized checks of audio_io_port against a queue-based model
module tb_audio_io_port;
   localparam int DW = 32, SW = 20, NCH = 2, DEPTH = 8;
`ifdef AUDIO_IO_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic              adc_valid = 1'b0, dac_tick = 1'b0;
   logic [0:0]        adc_ch = '0;
   logic [SW-1:0]     adc_data = '0;
   logic [NCH*SW-1:0] dac_out;
   logic              dac_valid, irq;
   audio_io_port_if #(.DWIDTH(DW)) bus();
   audio_io_port #(.DWIDTH(DW), .SWIDTH(SW), .NCH(NCH), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus), .i_adc_valid(adc_valid), .i_adc_ch(adc_ch),
      .i_adc_data(adc_data), .i_dac_tick(dac_tick), .o_dac_out(dac_out),
      .o_dac_valid(dac_valid), .o_irq(irq));
   int checks = 0, errors = 0;
   logic [SW-1:0] rxq [NCH][$];
   logic [SW-1:0] txq [NCH][$];
   logic [SW-1:0] m_dac [NCH];
   logic [7:0]    m_rov, m_und;
   logic [31:0]   m_mask, m_rdata;
   logic          m_irq, m_dv, m_tkq;
   function automatic logic [31:0] sx(input logic [SW-1:0] v);
      return {{(32-SW){v[SW-1]}}, v};
   endfunction
   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = {m_und, m_rov, 16'h0};
      for (int c = 0; c < NCH; c++) begin
         s[c]     = rxq[c].size() != 0;
         s[8 + c] = txq[c].size() == DEPTH;
      end
      return s;
   endfunction
   function automatic logic [NCH*SW-1:0] m_dac_vec();
      logic [NCH*SW-1:0] v;
      for (int c = 0; c < NCH; c++) v[c*SW +: SW] = m_dac[c];
      return v;
   endfunction
   task automatic m_clear();
      for (int c = 0; c < NCH; c++) begin
         rxq[c].delete();
         txq[c].delete();
         m_dac[c] = '0;
      end
      m_rov = 0; m_und = 0; m_mask = 0; m_rdata = 0; m_irq = 0; m_dv = 0; m_tkq = 0;
   endtask
   task automatic rst_assert();
      bus.ram_r = 0; bus.ram_w = 0; adc_valid = 0; dac_tick = 0;
      rst = 1'b1;
      m_clear();
      #1;
   endtask
   task automatic rst_release();
      @(negedge clk);
      rst = 1'b0;
   endtask
   // one bus/ADC/DAC cycle: drive inputs, advance the model by the behavioural rules, clock
   task automatic cyc(input logic rr, input logic ww, input logic [7:0] a, input logic [31:0] wd,
                      input logic av, input int ach, input logic [SW-1:0] ad, input logic tk);
      logic [31:0] st;
      logic [7:0]  rset, uset, clr;
      bus.ram_r = rr; bus.ram_w = ww; bus.addr = a; bus.wdata = wd;
      adc_valid = av; adc_ch = 1'(ach); adc_data = ad; dac_tick = tk;
      st = m_status(); rset = 0; uset = 0; clr = 0;
      m_irq = IRQ && |(st & m_mask);
      m_dv = m_tkq; m_tkq = tk;
      if (rr) m_rdata = (a < NCH) ? (rxq[a].size() != 0 ? sx(rxq[a][0]) : 32'h0) :
                        (a == 8'h20) ? st : (IRQ && a == 8'h22) ? m_mask : 32'h0;
      if (rr && a < NCH) begin
         if (rxq[a].size() != 0) void'(rxq[a].pop_front()); else uset[a] = 1'b1;
      end
      if (tk) for (int c = 0; c < NCH; c++) begin
         if (txq[c].size() != 0) m_dac[c] = txq[c].pop_front(); else uset[c] = 1'b1;
      end
      if (av) begin
         if (rxq[ach].size() < DEPTH) rxq[ach].push_back(ad); else rset[ach] = 1'b1;
      end
      if (ww && a >= 8'h10 && a < 8'h10 + NCH && txq[a-16].size() < DEPTH) txq[a-16].push_back(wd[SW-1:0]);
      if (ww && a == 8'h21) clr = 8'hFF;
      m_rov = (m_rov & ~(clr & wd[23:16])) | rset;
      m_und = (m_und & ~(clr & wd[31:24])) | uset;
      if (IRQ && ww && a == 8'h22) m_mask = wd;
      @(posedge clk);
      #1;
      bus.ram_r = 0; bus.ram_w = 0; adc_valid = 0; dac_tick = 0;
   endtask
   task automatic test_reset();
      rst_assert();
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
      checks++; if (dac_out !== '0) begin errors++; $display("FAIL reset_dac_out got %h exp 0", dac_out); end
      checks++; if (dac_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", dac_valid, irq); end
      rst_release();
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", bus.rdata); end
   endtask
   task automatic test_rx_sign();
      cyc(0, 0, 8'h00, 0, 1, 1, 20'h80001, 0);
      cyc(1, 0, 8'h01, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata !== 32'hFFF80001) begin errors++; $display("FAIL rx_sign got %h exp FFF80001", bus.rdata); end
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata[1] !== 1'b0) begin errors++; $display("FAIL rx_nonempty1 got %b exp 0", bus.rdata[1]); end
      cyc(1, 0, 8'h01, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata !== 32'h0 || m_rdata !== 32'h0) begin errors++; $display("FAIL rx_empty_read got %h exp 0", bus.rdata); end
   endtask
   task automatic test_rx_overflow();
      for (int k = 0; k < 9; k++) cyc(0, 0, 8'h00, 0, 1, 0, 20'(k * 3 + 1), 0);
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata[16] !== 1'b1) begin errors++; $display("FAIL rx_overflow_set got %b exp 1", bus.rdata[16]); end
      checks++; if (bus.rdata !== m_rdata) begin errors++; $display("FAIL ovf_status got %h exp %h", bus.rdata, m_rdata); end
      for (int k = 0; k < 8; k++) begin
         cyc(1, 0, 8'h00, 0, 0, 0, 0, 0);
         checks++; if (bus.rdata !== sx(20'(k * 3 + 1))) begin errors++; $display("FAIL rx_order%0d got %h exp %h", k, bus.rdata, sx(20'(k * 3 + 1))); end
      end
      cyc(0, 1, 8'h21, 32'h10000, 0, 0, 0, 0);
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata[16] !== 1'b0) begin errors++; $display("FAIL rx_overflow_clear got %b exp 0", bus.rdata[16]); end
   endtask
   task automatic test_dac();
      cyc(0, 1, 8'h10, 32'd5, 0, 0, 0, 0);
      cyc(0, 1, 8'h11, 32'd7, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 0, 1);
      checks++; if (dac_out !== {20'd7, 20'd5}) begin errors++; $display("FAIL dac_out got %h exp %h", dac_out, {20'd7, 20'd5}); end
      checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL dac_valid_early got %b exp 0", dac_valid); end
      cyc(0, 0, 8'h00, 0, 0, 0, 0, 0);
      checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL dac_valid got %b exp 1", dac_valid); end
      cyc(0, 0, 8'h00, 0, 0, 0, 0, 1);
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (dac_out !== {20'd7, 20'd5}) begin errors++; $display("FAIL dac_hold got %h exp %h", dac_out, {20'd7, 20'd5}); end
      checks++; if (bus.rdata[25:24] !== 2'b11) begin errors++; $display("FAIL tx_underrun got %b exp 11", bus.rdata[25:24]); end
   endtask
   task automatic test_full_push_pop();
      for (int k = 0; k < DEPTH; k++) cyc(0, 1, 8'h10, 32'(100 + k), 0, 0, 0, 0);
      cyc(0, 1, 8'h10, 32'd200, 0, 0, 0, 1);
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata[8] !== 1'b1) begin errors++; $display("FAIL tx_full_kept got %b exp 1", bus.rdata[8]); end
      checks++; if (dac_out[SW-1:0] !== 20'd100) begin errors++; $display("FAIL tx_first_pop got %h exp 100", dac_out[SW-1:0]); end
      cyc(0, 0, 8'h00, 0, 0, 0, 0, 1);
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata[8] !== 1'b0 || bus.rdata !== m_rdata) begin errors++; $display("FAIL tx_count7 got %h exp %h", bus.rdata, m_rdata); end
      cyc(0, 0, 8'h00, 0, 1, 1, 20'h12345, 1);
      cyc(0, 1, 8'h11, 32'd9, 1, 0, 20'h00042, 0);
      rst_assert();
      checks++; if (dac_out !== '0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL midburst_reset got %h/%h exp 0", dac_out, bus.rdata); end
      rst_release();
      cyc(1, 0, 8'h20, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL post_reset_status got %h exp 0", bus.rdata); end
   endtask
   task automatic test_irq();
      cyc(0, 1, 8'h22, 32'h10000, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) cyc(0, 0, 8'h00, 0, 1, 0, 20'(k), 0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", irq); end
      cyc(0, 0, 8'h00, 0, 0, 0, 0, 0);
      checks++; if (irq !== IRQ || irq !== m_irq) begin errors++; $display("FAIL irq_set got %b exp %b", irq, IRQ); end
      cyc(1, 0, 8'h22, 0, 0, 0, 0, 0);
      checks++; if (bus.rdata !== (IRQ ? 32'h10000 : 32'h0)) begin errors++; $display("FAIL irq_mask_read got %h exp %h", bus.rdata, m_rdata); end
      cyc(0, 1, 8'h21, 32'h10000, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 0, 0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
   endtask
   task automatic test_random();
      logic [7:0] alist [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h30};
      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, alist[$urandom_range(0, 8)], $urandom,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 20'($urandom), $urandom_range(0, 3) == 0);
         checks++; if (bus.rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata@%0d got %h exp %h", n, bus.rdata, m_rdata); end
         checks++; if (dac_out !== m_dac_vec()) begin errors++; $display("FAIL rnd_dac@%0d got %h exp %h", n, dac_out, m_dac_vec()); end
         checks++; if (dac_valid !== m_dv || irq !== m_irq) begin errors++; $display("FAIL rnd_valid_irq@%0d got %b%b exp %b%b", n, dac_valid, irq, m_dv, m_irq); end
      end
   endtask
   initial begin
      bus.ram_r = 0; bus.ram_w = 0; bus.addr = 0; bus.wdata = 0;
      test_reset();
      test_rx_sign();
      test_rx_overflow();
      test_dac();
      test_full_push_pop();
      test_irq();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
